// File: rtl/instr_encoder_loader_if.sv
// Request bus carrying one decoded instruction field set from the loader to the encoder.
// The master offers fields with req_valid; the slave signals acceptance with req_ready.
interface instr_encoder_loader_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [5:0]  func;
  logic [15:0] immediate;
  logic [25:0] instr_index;

  modport master (
    output req_valid, fmt, opcode, rs, rt, rd, sa, func, immediate, instr_index,
    input  req_ready
  );

  modport slave (
    input  req_valid, fmt, opcode, rs, rt, rd, sa, func, immediate, instr_index,
    output req_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Re-packs decoded MIPS fields into 32-bit words and streams them into instruction
// memory at consecutive addresses, one registered write per accepted legal request.
module instr_encoder_loader #(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   finish,
  instr_encoder_loader_if.slave  req,
  output logic                   imem_we,
  output logic [ADDR_W-1:0]      imem_addr,
  output logic [31:0]            imem_wdata,
  output logic [ADDR_W:0]        word_cnt,
  output logic                   bad_fmt,
  output logic                   full,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} state_t;

  localparam logic [1:0]        FMT_R     = 2'd0;
  localparam logic [1:0]        FMT_I     = 2'd1;
  localparam logic [1:0]        FMT_J     = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic              ready;
  logic              accept;
  logic [31:0]       enc;

  assign req.req_ready = ready;
  // ready is registered high exactly while in LOAD, so accept never depends on req_valid timing.
  assign accept = req.req_valid & ready;

  // NOTE: enc gets a default before the case so this block can never infer a latch.
  always_comb begin
    enc = '0;
    case (req.fmt)
      FMT_R:   enc = {req.opcode, req.rs, req.rt, req.rd, req.sa, req.func};
      FMT_I:   enc = {req.opcode, req.rs, req.rt, req.immediate};
      FMT_J:   enc = {req.opcode, req.instr_index};
      default: enc = '0;
    endcase
  end

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values
  // and later assignments in the same cycle (finish after an accept) simply take priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wptr       <= '0;
      ready      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_cnt   <= '0;
      bad_fmt    <= 1'b0;
      full       <= 1'b0;
      done       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wptr     <= base_addr;
            word_cnt <= '0;
            bad_fmt  <= 1'b0;
            full     <= 1'b0;
            ready    <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            if (req.fmt == 2'd3) begin
              bad_fmt <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= wptr;
              imem_wdata <= enc;
              word_cnt   <= word_cnt + CNT_ONE;
              // The top word ends the session's address space; the pointer never wraps.
              if (wptr == LAST_ADDR) begin
                full  <= 1'b1;
                ready <= 1'b0;
                state <= FULL;
              end else begin
                wptr <= wptr + PTR_ONE;
              end
            end
          end
          if (finish) begin
            ready <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        FULL: begin
          if (finish) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Packs decoded instruction fields (opcode, rs, rt, rd, sa, func, immediate, instr_index) back into 32-bit MIPS words and streams them into instruction memory at consecutive word addresses. It is the write-side counterpart of the fetch-stage field decoder and sits between the test/boot loader and the instruction-memory write port. A start/finish session model, a valid/ready request handshake and a one-stage registered write path give a fixed 1-cycle accept-to-write latency.

## Interface
Parameters:
- ADDR_W, 10, word-address width; memory holds 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; opens a load session (honoured only in IDLE).
- base_addr  in  ADDR_W  first word address; sampled with start.
- finish  in  1  one-cycle pulse; closes the session.
- req_valid  in  1  field set valid.
- req_ready  out  1  block accepts the field set this cycle.
- fmt  in  2  0 = R, 1 = I, 2 = J, 3 = illegal.
- opcode  in  6; rs, rt, rd, sa  in  5 each; func  in  6; immediate  in  16; instr_index  in  26: instruction fields.
- imem_we  out  1  memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- word_cnt  out  ADDR_W+1  words written this session.
- bad_fmt  out  1  sticky; an fmt = 3 request was seen this session.
- full  out  1  last memory word written; no further accepts.
- done  out  1  one-cycle pulse when the session closes.

## Operation
- Encoding:
  - R: {opcode, rs, rt, rd, sa, func}
  - I: {opcode, rs, rt, immediate}
  - J: {opcode, instr_index}
- States: IDLE, LOAD, FULL, DONE.
- IDLE:
  - req_ready = 0.
  - On start: wptr <= base_addr; word_cnt, bad_fmt and full are cleared; go to LOAD.
  - finish is ignored.
- LOAD:
  - req_ready = 1.
  - Accept = req_valid & req_ready. An accepted legal fmt schedules one write at wptr. wptr increments and word_cnt increments.
  - Accepted fmt = 3 sets bad_fmt. No write occurs, and wptr and word_cnt are unchanged.
  - Accepting a legal request at wptr = 2^ADDR_W-1 performs the write, sets full and moves to FULL. There is no wrap-around.
  - start in LOAD is ignored.
- FULL: req_ready = 0; finish moves to DONE.
- LOAD and finish in the same cycle as an accept: the request is processed normally, then the state becomes DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. req_ready = 0.
- word_cnt, bad_fmt and full hold their values after the session ends, until the next start.
- Reset, including mid-session: state IDLE; a pending write is dropped.
  - All outputs are 0: req_ready, imem_we, imem_addr, imem_wdata, word_cnt, bad_fmt, full and done.

## Timing
- req_ready is a registered function of state only. It does not depend on req_valid.
- Accept in cycle N gives imem_we = 1 in cycle N+1, with imem_addr = wptr at N and imem_wdata = the encoding at N.
- imem_we is a single-cycle strobe per accepted legal request. Back-to-back accepts give back-to-back writes at consecutive addresses.
- imem_addr and imem_wdata hold their last values when imem_we = 0.
- word_cnt, full and bad_fmt update in cycle N+1, aligned with the write.
- finish at N gives DONE at N+1 and done = 1 at N+1; the final write (if any) is also at N+1.
- The state returns to IDLE at N+2, so a new start is honoured from N+2.

## Test plan
- **R-type:** start with base_addr=0x010, then R request (op=0, rs=1, rt=2, rd=3, sa=0, func=0x20) -> next cycle imem_we=1, imem_addr=0x010, imem_wdata=0x00221820, word_cnt=1.
- **I/J back-to-back:** I request (op=0x08, rs=1, rt=2, imm=0xFFFF) then J request (op=0x02, index=0x0000100) on consecutive cycles -> 0x2022FFFF at 0x010, then 0x08000100 at 0x011, on consecutive cycles.
- **Illegal fmt:** fmt=3 accepted -> no imem_we, bad_fmt=1, word_cnt unchanged; a following legal request writes at the unchanged address.
- **Full boundary:** ADDR_W=4, base_addr=0xE, three legal requests offered back-to-back -> writes at 0xE and 0xF only, full=1, req_ready=0 from the cycle after the second accept, third request never accepted.
- **finish with accept, then restart:** finish coincident with an accept -> write occurs, done pulses once one cycle later, state IDLE; a new start clears word_cnt, bad_fmt and full.
- **Reset mid-session:** rst_n=0 in the cycle after an accept -> all outputs 0 on the next edge, no write emitted afterward, req_ready=0 until the next start.
